// File: rtl/prog_loader_ctrl.sv
// rtl/prog_loader_ctrl.sv - byte-stream program loader: length header, word assembly, imem/dmem write strobes
module prog_loader_ctrl #(
  parameter int ADDR_LEN  = 32,
  parameter int MAX_BYTES = 8192
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                prog_loading,
  output logic [ADDR_LEN-1:0] prog_loadaddr,
  output logic [127:0]        prog_loaddata,
  output logic                prog_dmem_we,
  output logic                prog_imem_we,
  output logic                done,
  output logic                err
);

  typedef enum logic [1:0] {S_HDR, S_DATA, S_FLUSH, S_DONE} state_t;

  state_t              r_state, w_state_next;
  logic [31:0]         r_cnt, r_len, r_word;
  logic [23:0]         r_hdr;
  logic                r_run;
  logic                r_err, r_dmem_we, r_imem_we;
  logic [ADDR_LEN-1:0] r_loadaddr;
  logic [127:0]        r_loaddata;

  logic                w_acc, w_last, w_wr;
  logic [31:0]         w_len, w_word;
  logic [ADDR_LEN-1:0] w_flush_addr, w_word_addr;

  assign in_ready      = r_run && (r_state == S_HDR || r_state == S_DATA);
  assign prog_loading  = (r_state != S_DONE);
  assign done          = (r_state == S_DONE);
  assign err           = r_err;
  assign prog_loadaddr = r_loadaddr;
  assign prog_loaddata = r_loaddata;
  assign prog_dmem_we  = r_dmem_we;
  assign prog_imem_we  = r_imem_we;

  // Bytes land at their little-endian lane; a fresh word starts zeroed so a short tail is zero-filled.
  always_comb begin
    w_acc        = in_valid && in_ready;
    w_len        = {in_data, r_hdr};
    w_word       = (r_cnt[1:0] == 2'd0) ? 32'h0 : r_word;
    w_word[{r_cnt[1:0], 3'b000} +: 8] = in_data;
    w_last       = (r_cnt + 32'd1 == r_len);
    w_wr         = w_acc && (r_state == S_DATA) && (r_cnt[1:0] == 2'd3 || w_last);
    w_flush_addr = r_loadaddr + ADDR_LEN'(4);
    w_word_addr  = ADDR_LEN'({r_cnt[31:2], 2'b00});
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_HDR: begin
        if (w_acc && r_cnt[1:0] == 2'd3) begin
          if (w_len > 32'(MAX_BYTES) || w_len == 32'd0) w_state_next = S_DONE;
          else                                         w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_wr && w_last) w_state_next = (r_cnt[3:2] == 2'd3) ? S_DONE : S_FLUSH;
      end
      S_FLUSH: begin
        if (w_flush_addr[3:2] == 2'd3) w_state_next = S_DONE;
      end
      default: w_state_next = S_DONE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_HDR;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= 32'd0;
      r_len      <= 32'd0;
      r_hdr      <= 24'd0;
      r_word     <= 32'd0;
      r_run      <= 1'b0;
      r_err      <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_imem_we  <= 1'b0;
      r_loadaddr <= '0;
      r_loaddata <= 128'd0;
    end else begin
      r_run     <= 1'b1;
      r_dmem_we <= 1'b0;
      r_imem_we <= 1'b0;
      case (r_state)
        S_HDR: begin
          if (w_acc) begin
            case (r_cnt[1:0])
              2'd0: r_hdr[7:0]   <= in_data;
              2'd1: r_hdr[15:8]  <= in_data;
              2'd2: r_hdr[23:16] <= in_data;
              default: begin
                r_len <= w_len;
                if (w_len > 32'(MAX_BYTES)) r_err <= 1'b1;
              end
            endcase
            r_cnt <= (r_cnt[1:0] == 2'd3) ? 32'd0 : r_cnt + 32'd1;
          end
        end
        S_DATA: begin
          if (w_acc) begin
            r_word <= w_word;
            r_cnt  <= r_cnt + 32'd1;
          end
          if (w_wr) begin
            r_loaddata <= {w_word, r_loaddata[127:32]};
            r_loadaddr <= w_word_addr;
            r_dmem_we  <= 1'b1;
            r_imem_we  <= (r_cnt[3:2] == 2'd3);
          end
        end
        S_FLUSH: begin
          r_loaddata <= {32'h0, r_loaddata[127:32]};
          r_loadaddr <= w_flush_addr;
          r_imem_we  <= (w_flush_addr[3:2] == 2'd3);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// tb/tb_prog_loader_ctrl.sv - scoreboard bench for prog_loader_ctrl
module tb_prog_loader_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h0;
  logic         in_ready, prog_loading, prog_dmem_we, prog_imem_we, done, err;
  logic [31:0]  prog_loadaddr;
  logic [127:0] prog_loaddata;

  prog_loader_ctrl #(.ADDR_LEN(32), .MAX_BYTES(8192)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .prog_loading(prog_loading),
    .prog_loadaddr(prog_loadaddr), .prog_loaddata(prog_loaddata),
    .prog_dmem_we(prog_dmem_we), .prog_imem_we(prog_imem_we),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         dmem;
    logic         imem;
    logic [31:0]  addr;
    logic [127:0] data;
  } ev_t;

  ev_t        exp_q[$];
  int         n_vec = 0;
  int         n_miss = 0;
  logic [7:0] img [0:255];

  function automatic void chk(input string tag, input logic [161:0] got, input logic [161:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endfunction

  // Strobe monitor: every strobe cycle must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!reset && (prog_dmem_we || prog_imem_we)) begin
      if (exp_q.size() == 0) chk("unexpected_strobe", {prog_dmem_we, prog_imem_we, prog_loadaddr}, 0);
      else chk("strobe", {prog_dmem_we, prog_imem_we, prog_loadaddr, prog_loaddata}, exp_q.pop_front());
    end
  end

  task automatic push_model(input int n);
    logic [127:0] sh = 128'h0;
    logic [31:0]  a = 32'h0;
    logic [31:0]  w;
    if (n == 0 || n > 8192) return;
    for (int i = 0; i < n; i += 4) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++) if (i + k < n) w[8*k +: 8] = img[i+k];
      a = i;
      sh = {w, sh[127:32]};
      exp_q.push_back('{1'b1, a[3:2] == 2'd3, a, sh});
    end
    while (a[3:2] != 2'd3) begin
      a = a + 32'd4;
      sh = {32'h0, sh[127:32]};
      if (a[3:2] == 2'd3) exp_q.push_back('{1'b0, 1'b1, a, sh});
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t = 0;
    if (gaps && $urandom_range(0, 1) == 1) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    while (!in_ready && t < 50) begin
      in_valid = 1'b0;
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("ready_timeout", in_ready, 1);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    exp_q.delete();
    chk("rst_outputs", {in_ready, prog_loading, prog_dmem_we, prog_imem_we, done, err, prog_loadaddr, prog_loaddata},
        {1'b0, 1'b1, 4'b0, 32'h0, 128'h0});
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
  endtask

  task automatic send_hdr(input int n, input bit gaps);
    logic [31:0] nv = n;
    for (int k = 0; k < 4; k++) send_byte(nv[8*k +: 8], gaps);
  endtask

  task automatic wait_done();
    int t = 0;
    in_valid = 1'b0;
    while (!done && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("done", done, 1);
  endtask

  task automatic run_load(input int n, input bit gaps);
    push_model(n);
    send_hdr(n, gaps);
    if (n > 0 && n <= 256)
      for (int i = 0; i < n; i++) send_byte(img[i], gaps);
    wait_done();
    repeat (2) @(negedge clk);
    chk("done_state", {done, prog_loading, in_ready}, 3'b100);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    do_reset();

    for (int i = 0; i < 16; i++) img[i] = 8'(i);
    run_load(16, 1'b0);
    chk("r32_data", prog_loaddata, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    chk("r32_err", err, 0);

    do_reset();
    img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC;
    img[3] = 8'hDD; img[4] = 8'hEE; img[5] = 8'hFF;
    run_load(6, 1'b0);
    chk("r33_data", prog_loaddata, 128'h00000000_00000000_0000FFEE_DDCCBBAA);
    chk("r33_addr", prog_loadaddr, 32'hC);

    do_reset();
    run_load(8193, 1'b0);
    chk("oversize_err", {err, done, prog_loading}, 3'b110);

    do_reset();
    run_load(0, 1'b0);
    chk("zero_len", {err, done, prog_loading}, 3'b010);

    do_reset();
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
    run_load(64, 1'b0);
    do_reset();
    run_load(64, 1'b1);

    do_reset();
    for (int i = 0; i < 16; i++) img[i] = 8'(8'h40 + i);
    send_hdr(16, 1'b0);
    push_model(16);
    for (int i = 0; i < 7; i++) send_byte(img[i], 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midload_rst", {in_ready, prog_loading, prog_dmem_we, prog_imem_we, done, err, prog_loadaddr, prog_loaddata},
        {1'b0, 1'b1, 4'b0, 32'h0, 128'h0});
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_midrst", in_ready, 1);
    for (int i = 0; i < 16; i++) img[i] = 8'(8'hA0 + i);
    run_load(16, 1'b1);
    chk("reload_data", prog_loaddata, 128'hAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
